register_s: RTL and testbench

REGISTER_S -- requirements
Module: register_s

---
 rtl/register_s_pkg.sv | 16 +
 rtl/register_s_if.sv | 31 +++
 rtl/register_s.sv | 43 ++++
 tb/tb_register_s.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/register_s_pkg.sv
// Shared constants for the register file built from register_s leaves.
// The register file uses these to build two banks of four registers.
package register_s_pkg;

  // Default data width of one register.
  localparam int DEF_WIDTH = 10;

  // Default reset value, kept at 64 bits and truncated per instance.
  localparam logic [63:0] DEF_RESET_VAL = 64'd0;

  // Register file organisation.
  localparam int NUM_BANKS      = 2;
  localparam int REGS_PER_BANK  = 4;
  localparam int NUM_REGS       = NUM_BANKS * REGS_PER_BANK;

endpackage

// File: rtl/register_s_if.sv
// Load bus for one register_s leaf. The master drives the load request,
// and the slave returns the stored value plus status.
interface register_s_if
  import register_s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             en;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             wr_ack;

  modport master (
    output en,
    output din,
    input  dout,
    input  valid,
    input  wr_ack
  );

  modport slave (
    input  en,
    input  din,
    output dout,
    output valid,
    output wr_ack
  );

endinterface

// File: rtl/register_s.sv
// Single loadable storage register with a sticky "loaded" flag and a
// one-cycle write acknowledge. It is a leaf: address decode and read
// multiplexing belong to the parent register file.
module register_s
  import register_s_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter logic [63:0] RESET_VAL = DEF_RESET_VAL
) (
  input  logic         clk,
  input  logic         rst,
  register_s_if.slave  bus
);

  // Reset value reduced to the register width.
  localparam logic [WIDTH-1:0] RST_DATA = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] data_p0;
  logic             vld_p0;
  logic             ack_p0;

  // Storage update: reset wins over load; the stored word itself is reset
  // because dout must show RESET_VAL right after the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= RST_DATA;
      vld_p0  <= 1'b0;
      ack_p0  <= 1'b0;
    end else begin
      if (bus.en) begin
        data_p0 <= bus.din;
        vld_p0  <= 1'b1;
      end
      ack_p0 <= bus.en;
    end
  end

  // ---- stage p0 boundary: outputs come straight from the registers ----
  assign bus.dout   = data_p0;
  assign bus.valid  = vld_p0;
  assign bus.wr_ack = ack_p0;

endmodule

// File: tb/tb_register_s.sv
// Directed bench for register_s: a table of per-edge vectors for the
// default 10-bit instance, plus short hand sequences for corner cases and
// a 4-bit instance with a non-zero reset value.
module tb_register_s;

  logic clk;
  logic rst;

  int checks;
  int failures;

  register_s_if #(.WIDTH(10)) bus10 ();
  register_s_if #(.WIDTH(4))  bus4 ();

  register_s #(.WIDTH(10), .RESET_VAL(64'd0)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10)
  );

  register_s #(.WIDTH(4), .RESET_VAL(64'd5)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [9:0]  din;
    logic [9:0]  exp_dout;
    logic        exp_valid;
    logic        exp_ack;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, sample 1ns later.
  task automatic step10(input logic r, input logic e, input logic [9:0] d);
    @(negedge clk);
    rst       = r;
    bus10.en  = e;
    bus10.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check10(input string tag, input logic [9:0] d, input logic v, input logic a);
    check({tag, ".dout"},   64'(bus10.dout),   64'(d));
    check({tag, ".valid"},  64'(bus10.valid),  64'(v));
    check({tag, ".wr_ack"}, 64'(bus10.wr_ack), 64'(a));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b0;
    bus10.en  = 1'b0;
    bus10.din = '0;
    bus4.en   = 1'b0;
    bus4.din  = '0;

    //               rst   en    din    dout  valid ack
    vecs[0]  = '{1'b1, 1'b1, 10'd15,   10'd0,    1'b0, 1'b0}; // reset with en=1
    vecs[1]  = '{1'b0, 1'b1, 10'd37,   10'd37,   1'b1, 1'b1}; // first load
    vecs[2]  = '{1'b0, 1'b0, 10'd42,   10'd37,   1'b1, 1'b0}; // hold
    vecs[3]  = '{1'b0, 1'b0, 10'd1023, 10'd37,   1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 10'd0,    10'd37,   1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 10'd42,   10'd37,   1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 10'd1023, 10'd37,   1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 10'd1023, 10'd1023, 1'b1, 1'b1}; // all ones
    vecs[8]  = '{1'b0, 1'b1, 10'd0,    10'd0,    1'b1, 1'b1}; // all zeros, back to back
    vecs[9]  = '{1'b0, 1'b0, 10'd5,    10'd0,    1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 10'd28,   10'd28,   1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 10'd35,   10'd0,    1'b0, 1'b0}; // rst beats en
    vecs[12] = '{1'b0, 1'b0, 10'd35,   10'd0,    1'b0, 1'b0}; // valid stays low
    vecs[13] = '{1'b0, 1'b1, 10'd35,   10'd35,   1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 10'd35,   10'd35,   1'b1, 1'b1}; // same value still loads
    vecs[15] = '{1'b0, 1'b0, 10'd35,   10'd35,   1'b1, 1'b0};

    for (int i = 0; i < 16; i++) begin
      step10(vecs[i].rst, vecs[i].en, vecs[i].din);
      check10($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_valid, vecs[i].exp_ack);
    end

    // Unknown din while en=0 must not disturb the stored value.
    step10(1'b0, 1'b0, 10'bx);
    check10("xdin", 10'd35, 1'b1, 1'b0);

    // Reset in the middle of a burst of loads clears everything at once.
    step10(1'b0, 1'b1, 10'd600);
    check10("burst0", 10'd600, 1'b1, 1'b1);
    step10(1'b0, 1'b1, 10'd601);
    check10("burst1", 10'd601, 1'b1, 1'b1);
    step10(1'b1, 1'b1, 10'd602);
    check10("burst_rst", 10'd0, 1'b0, 1'b0);
    step10(1'b1, 1'b0, 10'd603);
    check10("rst_hold", 10'd0, 1'b0, 1'b0);
    step10(1'b0, 1'b0, 10'd604);
    check10("post_rst", 10'd0, 1'b0, 1'b0);
    step10(1'b0, 1'b1, 10'd513);
    check10("reload", 10'd513, 1'b1, 1'b1);
    step10(1'b0, 1'b0, 10'd0);
    check10("ack_drop", 10'd513, 1'b1, 1'b0);

    // 4-bit instance with RESET_VAL=5.
    @(negedge clk);
    rst      = 1'b1;
    bus4.en  = 1'b1;
    bus4.din = 4'd9;
    @(posedge clk);
    #1;
    check("w4.rst.dout",  64'(bus4.dout),   64'd5);
    check("w4.rst.valid", 64'(bus4.valid),  64'd0);
    check("w4.rst.ack",   64'(bus4.wr_ack), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    bus4.en  = 1'b1;
    bus4.din = 4'd15;
    @(posedge clk);
    #1;
    check("w4.load.dout",  64'(bus4.dout),   64'd15);
    check("w4.load.valid", 64'(bus4.valid),  64'd1);
    check("w4.load.ack",   64'(bus4.wr_ack), 64'd1);
    @(negedge clk);
    bus4.en  = 1'b0;
    bus4.din = 4'd3;
    @(posedge clk);
    #1;
    check("w4.hold.dout", 64'(bus4.dout),   64'd15);
    check("w4.hold.ack",  64'(bus4.wr_ack), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
